// File: rtl/ds18b20_display_mux.sv
// rtl/ds18b20_display_mux.sv - DS18B20 temperature to multiplexed seven-segment display driver
module ds18b20_display_mux #(
  parameter int DIGITS         = 4,
  parameter int FRAC_DIGITS    = 1,
  parameter int SCAN_DIV_LOG2  = 13,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       temp_i,
  input  logic              temp_valid_i,
  output logic              busy_o,
  output logic              sign_o,
  output logic              overflow_o,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [DIGITS-1:0] digit_sel_o
);

  // Integer positions available on the display, limited by the 4-digit BCD accumulator.
  localparam int INT_POS = ((DIGITS - FRAC_DIGITS) > 4) ? 4 : (DIGITS - FRAC_DIGITS);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [13:0] MAX_INT = (INT_POS == 1) ? 14'd9   :
                                    (INT_POS == 2) ? 14'd99  :
                                    (INT_POS == 3) ? 14'd999 : 14'd9999;
  localparam logic [6:0] GLYPH_DASH = 7'b0000001;
  localparam logic [6:0] GLYPH_ZERO = 7'b1111110;
  localparam logic       POL        = (SEG_ACTIVE_LOW != 0);

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t state, state_nx;
  logic   capture, commit;

  logic [15:0] mag_raw, mag;
  logic [7:0]  frac_prod;
  logic [15:0] bcd, bcd_adj;
  logic [11:0] int_sr, int_q;
  logic [3:0]  frac_q, shift_cnt;
  logic        neg_q;
  logic        ovf_nx;

  logic [DIGITS-1:0][6:0] disp_seg, new_seg, rst_seg;
  logic [DIGITS-1:0]      disp_dp, new_dp, rst_dp;
  logic [3:0]             digit;
  int                     k_pos;

  logic [SCAN_DIV_LOG2-1:0] scan_cnt;
  logic [IDX_W-1:0]         idx, idx_nx;

  // Conversion state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and capture/commit strobes; strobes outside IDLE are dropped.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (temp_valid_i) begin
          capture  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT:   if (shift_cnt == 4'd11) state_nx = COMMIT;
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Magnitude of the input word (0x8000 saturates) and the truncated tenths digit.
  always_comb begin
    mag_raw   = temp_i[15] ? (~temp_i + 16'd1) : temp_i;
    mag       = mag_raw[15] ? 16'h7FFF : mag_raw;
    frac_prod = {4'd0, mag[3:0]} * 8'd10;
  end

  // Shift-add-3 correction applied to each BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
  end

  // Capture registers and the binary-to-BCD shift engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd       <= '0;
      int_sr    <= '0;
      int_q     <= '0;
      frac_q    <= '0;
      neg_q     <= 1'b0;
      shift_cnt <= '0;
    end else if (capture) begin
      bcd       <= '0;
      int_sr    <= mag[15:4];
      int_q     <= mag[15:4];
      frac_q    <= frac_prod[7:4];
      neg_q     <= temp_i[15];
      shift_cnt <= '0;
    end else if (state == SHIFT) begin
      bcd       <= {bcd_adj[14:0], int_sr[11]};
      int_sr    <= {int_sr[10:0], 1'b0};
      shift_cnt <= shift_cnt + 4'd1;
    end
  end

  // Busy tracks the upcoming state so it rises with the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) busy_o <= 1'b0;
    else     busy_o <= (state_nx != IDLE);
  end

  // Display image for the finished conversion: blanking, tenths, decimal point, dashes.
  always_comb begin
    ovf_nx  = ({2'b00, int_q} > MAX_INT);
    new_seg = '0;
    new_dp  = '0;
    digit   = '0;
    k_pos   = 0;
    for (int p = 0; p < DIGITS; p++) begin
      if (ovf_nx) begin
        new_seg[p] = GLYPH_DASH;
      end else if (FRAC_DIGITS == 1 && p == 0) begin
        new_seg[p] = glyph(frac_q);
      end else if (p < INT_POS + FRAC_DIGITS) begin
        k_pos = p - FRAC_DIGITS;
        digit = 4'(bcd >> (4 * k_pos));
        if (k_pos == 0 || (bcd >> (4 * k_pos)) != 16'd0) new_seg[p] = glyph(digit);
      end
    end
    if (FRAC_DIGITS == 1 && !ovf_nx) new_dp[1] = 1'b1;
  end

  // Power-up image: "0" in the units position (and tenths), all else blank.
  always_comb begin
    rst_seg = '0;
    rst_dp  = '0;
    for (int p = 0; p < DIGITS; p++) begin
      if (p == 0 || p == FRAC_DIGITS) rst_seg[p] = GLYPH_ZERO;
    end
    if (FRAC_DIGITS == 1) rst_dp[1] = 1'b1;
  end

  // Display buffer and status flags load atomically at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_seg   <= rst_seg;
      disp_dp    <= rst_dp;
      sign_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (commit) begin
      disp_seg   <= new_seg;
      disp_dp    <= new_dp;
      sign_o     <= neg_q && (int_q != 12'd0 || frac_q != 4'd0);
      overflow_o <= ovf_nx;
    end
  end

  // Position index advances when the free-running divider wraps.
  always_comb begin
    idx_nx = idx;
    if (&scan_cnt) idx_nx = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  // Scan outputs: digit enable and its glyph are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= '0;
      digit_sel_o <= DIGITS'(1);
      seg_o       <= GLYPH_ZERO ^ {7{POL}};
      dp_o        <= POL;
    end else begin
      scan_cnt    <= scan_cnt + 1'b1;
      idx         <= idx_nx;
      digit_sel_o <= DIGITS'(1) << idx_nx;
      seg_o       <= disp_seg[idx_nx] ^ {7{POL}};
      dp_o        <= disp_dp[idx_nx] ^ POL;
    end
  end

endmodule

// File: tb/tb_ds18b20_display_mux.sv
// tb/tb_ds18b20_display_mux.sv - directed vector bench for ds18b20_display_mux
module tb_ds18b20_display_mux;

  localparam logic [6:0] G0 = 7'b1111110, G1 = 7'b0110000, G2 = 7'b1101101, G3 = 7'b1111001;
  localparam logic [6:0] G5 = 7'b1011011, G9 = 7'b1111011;
  localparam logic [6:0] BL = 7'b0000000, DS = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] temp;
  logic        valid;

  logic       busy_a, sign_a, ovf_a, dp_a;
  logic [6:0] seg_a;
  logic [3:0] sel_a;
  logic       busy_b, sign_b, ovf_b, dp_b;
  logic [6:0] seg_b;
  logic [2:0] sel_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [27:0] got_a;
  logic [3:0]  got_dpa;
  logic [20:0] got_b;
  logic [2:0]  got_dpb;

  typedef struct {
    logic [15:0] t;
    logic [27:0] ea;
    logic [3:0]  dpa;
    logic [20:0] eb;
    logic [2:0]  dpb;
    logic        sg;
    logic        oa;
    logic        ob;
  } vec_t;

  vec_t vt[12];

  always #5 clk = ~clk;

  ds18b20_display_mux #(.DIGITS(4), .FRAC_DIGITS(1), .SCAN_DIV_LOG2(4), .SEG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .temp_i(temp), .temp_valid_i(valid),
    .busy_o(busy_a), .sign_o(sign_a), .overflow_o(ovf_a),
    .seg_o(seg_a), .dp_o(dp_a), .digit_sel_o(sel_a)
  );

  ds18b20_display_mux #(.DIGITS(3), .FRAC_DIGITS(1), .SCAN_DIV_LOG2(4), .SEG_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .temp_i(temp), .temp_valid_i(valid),
    .busy_o(busy_b), .sign_o(sign_b), .overflow_o(ovf_b),
    .seg_o(seg_b), .dp_o(dp_b), .digit_sel_o(sel_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Strobe one word at the current negedge and time the busy window.
  task automatic run_conv(input logic [15:0] t);
    int cnt;
    temp  = t;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("busy_rise", {31'd0, busy_a}, 32'd1);
    cnt = 0;
    while (busy_a && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_len", cnt, 32'd13);
  endtask

  // Sample both scanned displays long enough to see every position.
  task automatic collect();
    logic [3:0] seen_a;
    logic [2:0] seen_b;
    int bad;
    seen_a = '0;
    seen_b = '0;
    bad    = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        if (sel_a == 4'(1 << p)) begin
          got_a[p*7 +: 7] = ~seg_a;
          got_dpa[p]      = ~dp_a;
          seen_a[p]       = 1'b1;
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (sel_b == 3'(1 << p)) begin
          got_b[p*7 +: 7] = seg_b;
          got_dpb[p]      = dp_b;
          seen_b[p]       = 1'b1;
        end
      end
      if ($countones(sel_a) != 1 || $countones(sel_b) != 1) bad++;
    end
    check("scan_onehot", bad, 32'd0);
    check("scan_cover", {25'd0, seen_b, seen_a}, 32'h7F);
  endtask

  initial begin
    int   cnt;
    int   run;
    logic [3:0] cur, nxt;

    vt[0]  = '{16'h0198, {BL, G2, G5, G5}, 4'b0010, {G2, G5, G5}, 3'b010, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{16'hFC90, {BL, G5, G5, G0}, 4'b0010, {G5, G5, G0}, 3'b010, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{16'h07D0, {G1, G2, G5, G0}, 4'b0010, {DS, DS, DS}, 3'b000, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{16'hFFFF, {BL, BL, G0, G0}, 4'b0010, {BL, G0, G0}, 3'b010, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{16'hFFF8, {BL, BL, G0, G5}, 4'b0010, {BL, G0, G5}, 3'b010, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{16'h8000, {DS, DS, DS, DS}, 4'b0000, {DS, DS, DS}, 3'b000, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{16'h0005, {BL, BL, G0, G3}, 4'b0010, {BL, G0, G3}, 3'b010, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{16'h0630, {BL, G9, G9, G0}, 4'b0010, {G9, G9, G0}, 3'b010, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{16'h3E70, {G9, G9, G9, G0}, 4'b0010, {DS, DS, DS}, 3'b000, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{16'h3E80, {DS, DS, DS, DS}, 4'b0000, {DS, DS, DS}, 3'b000, 1'b0, 1'b1, 1'b1};
    vt[10] = '{16'h0640, {G1, G0, G0, G0}, 4'b0010, {DS, DS, DS}, 3'b000, 1'b0, 1'b0, 1'b1};
    vt[11] = '{16'h019F, {BL, G2, G5, G9}, 4'b0010, {G2, G5, G9}, 3'b010, 1'b0, 1'b0, 1'b0};

    rst   = 1'b1;
    valid = 1'b0;
    temp  = 16'h0000;
    repeat (3) @(negedge clk);

    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_sign", {30'd0, sign_a, sign_b}, 32'd0);
    check("rst_ovf", {30'd0, ovf_a, ovf_b}, 32'd0);
    check("rst_sel_a", {28'd0, sel_a}, 32'h1);
    check("rst_sel_b", {29'd0, sel_b}, 32'h1);
    check("rst_seg_a", {25'd0, seg_a}, 32'h01);
    check("rst_dp_a", {31'd0, dp_a}, 32'd1);
    check("rst_seg_b", {25'd0, seg_b}, {25'd0, G0});
    check("rst_dp_b", {31'd0, dp_b}, 32'd0);
    rst = 1'b0;

    // Scan cadence: each one-hot position held for 16 cycles.
    cnt = 0;
    while (sel_a != 4'b0010 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("scan_first", {28'd0, sel_a}, 32'h2);
    cur = 4'b0010;
    for (int s = 0; s < 3; s++) begin
      nxt = (cur == 4'b1000) ? 4'b0001 : (cur << 1);
      run = 1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (sel_a == cur) run++;
        else break;
      end
      check($sformatf("scan_hold_%0h", cur), run, 32'd16);
      check($sformatf("scan_next_%0h", cur), {28'd0, sel_a}, {28'd0, nxt});
      cur = nxt;
    end

    collect();
    check("rst_img_a", {4'd0, got_a}, {4'd0, BL, BL, G0, G0});
    check("rst_dp_img_a", {28'd0, got_dpa}, 32'h2);
    check("rst_img_b", {11'd0, got_b}, {11'd0, BL, G0, G0});
    check("rst_dp_img_b", {29'd0, got_dpb}, 32'h2);

    for (int i = 0; i < 12; i++) begin
      run_conv(vt[i].t);
      collect();
      check($sformatf("v%0d_seg_a", i), {4'd0, got_a}, {4'd0, vt[i].ea});
      check($sformatf("v%0d_dp_a", i), {28'd0, got_dpa}, {28'd0, vt[i].dpa});
      check($sformatf("v%0d_seg_b", i), {11'd0, got_b}, {11'd0, vt[i].eb});
      check($sformatf("v%0d_dp_b", i), {29'd0, got_dpb}, {29'd0, vt[i].dpb});
      check($sformatf("v%0d_sign", i), {30'd0, sign_a, sign_b}, {30'd0, vt[i].sg, vt[i].sg});
      check($sformatf("v%0d_ovf_a", i), {31'd0, ovf_a}, {31'd0, vt[i].oa});
      check($sformatf("v%0d_ovf_b", i), {31'd0, ovf_b}, {31'd0, vt[i].ob});
    end

    // Back-to-back: second strobe lands on E14 and must be accepted.
    run_conv(16'h0198);
    run_conv(16'hFC90);
    collect();
    check("b2b_seg_a", {4'd0, got_a}, {4'd0, BL, G5, G5, G0});
    check("b2b_sign", {31'd0, sign_a}, 32'd1);

    // Reset at E6 aborts the conversion and restores the power-up image.
    temp  = 16'h0198;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_sign", {31'd0, sign_a}, 32'd0);
    check("abort_sel", {28'd0, sel_a}, 32'h1);
    repeat (20) @(negedge clk);
    check("abort_no_resume", {30'd0, busy_a, busy_b}, 32'd0);
    collect();
    check("abort_img_a", {4'd0, got_a}, {4'd0, BL, BL, G0, G0});
    check("abort_dp_a", {28'd0, got_dpa}, 32'h2);
    check("abort_ovf", {30'd0, ovf_a, ovf_b}, 32'd0);

    // Strobe during SHIFT (E5) is dropped; 25.0 commits on schedule.
    temp  = 16'h0190;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    temp  = 16'h07D0;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    cnt = 5;
    while (busy_a && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("drop_busy_len", cnt, 32'd13);
    collect();
    check("drop_seg_a", {4'd0, got_a}, {4'd0, BL, G2, G5, G0});
    check("drop_seg_b", {11'd0, got_b}, {11'd0, G2, G5, G0});
    check("drop_ovf_b", {31'd0, ovf_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
